// File: rtl/memory_stage.sv
// memory_stage: single-outstanding data-memory stage. Steers store lanes, aligns and
// extends load data, flags misaligned accesses and registers the writeback port.
module memory_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_wb_addr,
    input  logic            ex_rf_wen,
    input  logic            ex_mem_val,
    input  logic [1:0]      ex_mem_fcn,
    input  logic [2:0]      ex_mem_typ,
    input  logic [1:0]      ex_wb_sel,

    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic            dmem_req_wen,
    output logic [3:0]      dmem_req_be,
    output logic [XLEN-1:0] dmem_req_wdata,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,

    output logic            mem_stall,
    output logic            mem_misaligned,

    output logic [4:0]      mem_wb_addr,
    output logic            mem_rf_wen,
    output logic [XLEN-1:0] mem_wb_data,

    output logic [4:0]      wb_addr,
    output logic            wb_rf_wen,
    output logic [XLEN-1:0] wb_data
);

    localparam logic [1:0] M_XRD  = 2'd1;
    localparam logic [1:0] M_XWR  = 2'd2;
    localparam logic [2:0] MT_B   = 3'd1;
    localparam logic [2:0] MT_H   = 3'd2;
    localparam logic [2:0] MT_W   = 3'd3;
    localparam logic [2:0] MT_BU  = 3'd5;
    localparam logic [2:0] MT_HU  = 3'd6;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      wb_addr;
        logic            rf_wen;
        logic            mem_val;
        logic [1:0]      mem_fcn;
        logic [2:0]      mem_typ;
        logic [1:0]      wb_sel;
    } ms_t;

    state_e          state, state_nxt;
    ms_t             ms;
    logic [1:0]      byte_off;
    logic            is_rd, is_wr, mem_op, misaligned;
    logic            store_done, load_done;
    logic [XLEN-1:0] load_data;

    // A bubble is an all-zero stage register: no write, no memory op, x0 destination.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            ms <= '0;
        end else if (!mem_stall) begin
            if (ex_valid) begin
                ms <= '{pc: ex_pc, alu_out: ex_alu_out, rs2_data: ex_rs2_data,
                        wb_addr: ex_wb_addr, rf_wen: ex_rf_wen, mem_val: ex_mem_val,
                        mem_fcn: ex_mem_fcn, mem_typ: ex_mem_typ, wb_sel: ex_wb_sel};
            end else begin
                ms <= '0;
            end
        end
    end

    assign byte_off = ms.alu_out[1:0];
    assign is_rd    = (ms.mem_fcn == M_XRD);
    assign is_wr    = (ms.mem_fcn == M_XWR);
    assign mem_op   = ms.mem_val && (is_rd || is_wr);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        misaligned = 1'b0;
        if (mem_op) begin
            case (ms.mem_typ)
                MT_H, MT_HU: misaligned = byte_off[0];
                MT_W:        misaligned = (byte_off != 2'd0);
                default:     misaligned = 1'b0;
            endcase
        end
    end

    assign dmem_req_valid = (state == S_IDLE) && mem_op && !misaligned;
    assign dmem_req_addr  = {ms.alu_out[XLEN-1:2], 2'b00};
    assign dmem_req_wen   = mem_op && is_wr;

    always_comb begin
        dmem_req_be    = 4'b0000;
        dmem_req_wdata = '0;
        if (mem_op && is_rd) begin
            dmem_req_be = 4'b1111;
        end else if (mem_op && is_wr) begin
            case (ms.mem_typ)
                MT_B, MT_BU: begin
                    dmem_req_be    = 4'b0001 << byte_off;
                    dmem_req_wdata = {4{ms.rs2_data[7:0]}};
                end
                MT_H, MT_HU: begin
                    dmem_req_be    = 4'b0011 << byte_off;
                    dmem_req_wdata = {2{ms.rs2_data[15:0]}};
                end
                default: begin
                    dmem_req_be    = 4'b1111;
                    dmem_req_wdata = ms.rs2_data;
                end
            endcase
        end
    end

    assign store_done     = dmem_req_valid && dmem_req_ready && is_wr;
    assign load_done      = (state == S_WAIT) && dmem_resp_valid;
    assign mem_stall      = mem_op && !(store_done || load_done || misaligned);
    assign mem_misaligned = misaligned;

    // Only loads wait for a response; stores retire in their accept cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (dmem_req_valid && dmem_req_ready && is_rd) state_nxt = S_WAIT;
            S_WAIT: if (dmem_resp_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        load_data = dmem_resp_rdata;
        case (ms.mem_typ)
            MT_B:  load_data = {{24{load_data[{byte_off, 3'b111}]}}, dmem_resp_rdata[{byte_off, 3'b000} +: 8]};
            MT_BU: load_data = {24'b0, dmem_resp_rdata[{byte_off, 3'b000} +: 8]};
            MT_H:  load_data = {{16{dmem_resp_rdata[{byte_off[1], 4'b1111}]}},
                                dmem_resp_rdata[{byte_off[1], 4'b0000} +: 16]};
            MT_HU: load_data = {16'b0, dmem_resp_rdata[{byte_off[1], 4'b0000} +: 16]};
            default: load_data = dmem_resp_rdata;
        endcase
    end

    always_comb begin
        case (ms.wb_sel)
            WB_ALU:  mem_wb_data = ms.alu_out;
            WB_MEM:  mem_wb_data = load_data;
            WB_PC4:  mem_wb_data = ms.pc + XLEN'(4);
            default: mem_wb_data = '0;
        endcase
    end

    assign mem_wb_addr = ms.wb_addr;
    assign mem_rf_wen  = ms.rf_wen && !misaligned && ((ms.wb_sel != WB_MEM) || load_done);

    always_ff @(posedge clk) begin
        if (!rst_n || mem_stall) begin
            wb_addr   <= '0;
            wb_rf_wen <= 1'b0;
            wb_data   <= '0;
        end else begin
            wb_addr   <= mem_wb_addr;
            wb_rf_wen <= mem_rf_wen;
            wb_data   <= mem_wb_data;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scenarios followed by a randomized instruction stream
// checked against a queue-based model of memory requests and register writebacks.
module tb_memory_stage;

    localparam logic [1:0] M_XRD  = 2'd1;
    localparam logic [1:0] M_XWR  = 2'd2;
    localparam logic [2:0] MT_B   = 3'd1;
    localparam logic [2:0] MT_H   = 3'd2;
    localparam logic [2:0] MT_W   = 3'd3;
    localparam logic [2:0] MT_BU  = 3'd5;
    localparam logic [2:0] MT_HU  = 3'd6;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam int N_INSTR = 300;
    localparam int BUDGET  = 6000;

    logic clk = 1'b0;
    logic rst_n;
    logic ex_valid, ex_rf_wen, ex_mem_val;
    logic [31:0] ex_pc, ex_alu_out, ex_rs2_data;
    logic [4:0]  ex_wb_addr;
    logic [1:0]  ex_mem_fcn, ex_wb_sel;
    logic [2:0]  ex_mem_typ;
    logic dmem_req_valid, dmem_req_ready, dmem_req_wen, dmem_resp_valid;
    logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata;
    logic [3:0]  dmem_req_be;
    logic mem_stall, mem_misaligned, mem_rf_wen, wb_rf_wen;
    logic [4:0]  mem_wb_addr, wb_addr;
    logic [31:0] mem_wb_data, wb_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
        .ex_wb_addr(ex_wb_addr), .ex_rf_wen(ex_rf_wen), .ex_mem_val(ex_mem_val),
        .ex_mem_fcn(ex_mem_fcn), .ex_mem_typ(ex_mem_typ), .ex_wb_sel(ex_wb_sel),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen), .dmem_req_be(dmem_req_be),
        .dmem_req_wdata(dmem_req_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_rdata(dmem_resp_rdata), .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
        .mem_wb_addr(mem_wb_addr), .mem_rf_wen(mem_rf_wen), .mem_wb_data(mem_wb_data),
        .wb_addr(wb_addr), .wb_rf_wen(wb_rf_wen), .wb_data(wb_data)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  wb_addr;
        logic        rf_wen;
        logic        mem_val;
        logic [1:0]  fcn;
        logic [2:0]  typ;
        logic [1:0]  wb_sel;
    } instr_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   exp_mis = 0;
    int   obs_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_t t);
        ex_valid    = t.valid;
        ex_pc       = t.pc;
        ex_alu_out  = t.alu;
        ex_rs2_data = t.rs2;
        ex_wb_addr  = t.wb_addr;
        ex_rf_wen   = t.rf_wen;
        ex_mem_val  = t.mem_val;
        ex_mem_fcn  = t.fcn;
        ex_mem_typ  = t.typ;
        ex_wb_sel   = t.wb_sel;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] wa, input logic rfw, input logic mv,
                          input logic [1:0] fcn, input logic [2:0] typ, input logic [1:0] sel);
        drive('{valid: 1'b1, pc: pc, alu: alu, rs2: rs2, wb_addr: wa, rf_wen: rfw,
                mem_val: mv, fcn: fcn, typ: typ, wb_sel: sel});
    endtask

    task automatic set_bubble();
        drive('0);
    endtask

    // Deterministic memory contents, keyed by word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) * 32'h9E37_79B1;
    endfunction

    // Arithmetic picture of a load: shift the lane down, mask it, then sign-correct.
    function automatic logic [31:0] load_value(input logic [31:0] word, input int off, input logic [2:0] typ);
        int unsigned w = word;
        int v;
        case (typ)
            MT_B, MT_BU: begin
                v = int'((w >> (8 * off)) % 256);
                if (typ == MT_B && v >= 128) v -= 256;
            end
            MT_H, MT_HU: begin
                v = int'((w >> (16 * (off / 2))) % 65536);
                if (typ == MT_H && v >= 32768) v -= 65536;
            end
            default: v = int'(w);
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pick_typ(input bit is_load);
        case ($urandom_range(0, is_load ? 4 : 2))
            0:       return MT_B;
            1:       return MT_H;
            2:       return MT_W;
            3:       return MT_BU;
            default: return MT_HU;
        endcase
    endfunction

    function automatic instr_t gen_instr();
        instr_t t = '0;
        t.valid   = 1'b1;
        t.pc      = $urandom;
        t.alu     = $urandom;
        t.rs2     = $urandom;
        t.wb_addr = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0, 1: begin t.rf_wen = 1'($urandom_range(0, 1)); t.wb_sel = WB_ALU; end
            2: begin
                t.rf_wen = 1'b1; t.wb_sel = WB_PC4;
                if ($urandom_range(0, 3) == 0) t.pc = 32'hFFFF_FFFC;
            end
            3: begin
                t.mem_val = 1'b1; t.fcn = M_XRD; t.typ = pick_typ(1'b1);
                t.alu = 32'h1000 + 32'($urandom_range(0, 63)); t.rf_wen = 1'b1; t.wb_sel = WB_MEM;
            end
            4: begin
                t.mem_val = 1'b1; t.fcn = M_XWR; t.typ = pick_typ(1'b0);
                t.alu = 32'h1000 + 32'($urandom_range(0, 63)); t.rf_wen = 1'b0; t.wb_sel = WB_ALU;
            end
            default: begin
                t.valid = 1'b0; t.mem_val = 1'b1; t.fcn = M_XRD; t.rf_wen = 1'b1; t.wb_sel = WB_MEM;
            end
        endcase
        return t;
    endfunction

    // Record what an instruction must produce once it enters the stage.
    task automatic model_push(input instr_t t);
        bit is_mem, is_half, mis;
        int off;
        req_t r;
        wb_t w;
        if (!t.valid) return;
        is_mem  = t.mem_val && (t.fcn == M_XRD || t.fcn == M_XWR);
        off     = int'(t.alu % 4);
        is_half = (t.typ == MT_H || t.typ == MT_HU);
        mis     = is_mem && ((is_half && off % 2 == 1) || (t.typ == MT_W && off != 0));
        if (mis) exp_mis++;
        if (is_mem && !mis) begin
            r.addr  = t.alu - 32'(off);
            r.wen   = (t.fcn == M_XWR);
            r.be    = 4'hF;
            r.wdata = t.rs2;
            if (r.wen && (t.typ == MT_B || t.typ == MT_BU)) begin
                r.be = 4'(1 << off); r.wdata = (t.rs2 % 256) * 32'h0101_0101;
            end else if (r.wen && is_half) begin
                r.be = 4'(3 << off); r.wdata = (t.rs2 % 65536) * 32'h0001_0001;
            end
            req_q.push_back(r);
        end
        if (t.rf_wen && !mis && (t.wb_sel != WB_MEM || (is_mem && t.fcn == M_XRD))) begin
            w.addr = t.wb_addr;
            case (t.wb_sel)
                WB_ALU:  w.data = t.alu;
                WB_PC4:  w.data = t.pc + 32'd4;
                WB_MEM:  w.data = load_value(mem_word(t.alu - 32'(off)), off, t.typ);
                default: w.data = 32'd0;
            endcase
            wb_q.push_back(w);
        end
    endtask

    initial begin
        int stall_cnt;
        int cyc;
        int issued;
        int resp_wait;
        bit resp_pend;
        logic [31:0] resp_addr;
        instr_t cur;
        req_t r;
        wb_t w;

        rst_n = 1'b0;
        set_bubble();
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = 32'h0;
        tick(); tick();
        chk1("rst_req_valid", dmem_req_valid, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_misaligned", mem_misaligned, 1'b0);
        chk1("rst_wb_rf_wen", wb_rf_wen, 1'b0);
        chk1("rst_mem_rf_wen", mem_rf_wen, 1'b0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_req_be", 32'(dmem_req_be), 32'h0);
        rst_n = 1'b1;

        // LB at 0x103, response after two idle wait cycles.
        set_ex(32'h0, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, M_XRD, MT_B, WB_MEM);
        dmem_req_ready = 1'b1;
        tick();
        set_bubble();
        stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            dmem_resp_valid = (c == 3);
            dmem_resp_rdata = (c == 3) ? 32'h80FF_FF00 : 32'hDEAD_BEEF;
            #1;
            if (c == 0) begin
                chk1("lb_req_valid", dmem_req_valid, 1'b1);
                check("lb_req_addr", dmem_req_addr, 32'h100);
                check("lb_req_be", 32'(dmem_req_be), 32'hF);
                chk1("lb_req_wen", dmem_req_wen, 1'b0);
            end else begin
                chk1("lb_no_req", dmem_req_valid, 1'b0);
            end
            if (mem_stall) stall_cnt++;
            if (c == 3) begin
                check("lb_bypass_data", mem_wb_data, 32'hFFFF_FF80);
                chk1("lb_bypass_wen", mem_rf_wen, 1'b1);
            end
            tick();
        end
        dmem_resp_valid = 1'b0;
        #1;
        check("lb_stall_cycles", 32'(stall_cnt), 32'd3);
        chk1("lb_wb_rf_wen", wb_rf_wen, 1'b1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_addr", 32'(wb_addr), 32'd7);

        // SH at 0x102 with two cycles of backpressure.
        set_ex(32'h0, 32'h102, 32'h0000_BEEF, 5'd0, 1'b0, 1'b1, M_XWR, MT_H, WB_ALU);
        dmem_req_ready = 1'b0;
        tick();
        set_bubble();
        for (int c = 0; c < 3; c++) begin
            dmem_req_ready = (c == 2);
            #1;
            chk1("sh_req_valid", dmem_req_valid, 1'b1);
            check("sh_req_addr", dmem_req_addr, 32'h100);
            check("sh_req_be", 32'(dmem_req_be), 32'hC);
            check("sh_req_wdata", dmem_req_wdata, 32'hBEEF_BEEF);
            chk1("sh_req_wen", dmem_req_wen, 1'b1);
            chk1("sh_stall", mem_stall, c != 2);
            tick();
        end
        dmem_req_ready = 1'b0;
        #1;
        chk1("sh_done_req", dmem_req_valid, 1'b0);
        chk1("sh_done_stall", mem_stall, 1'b0);

        // Misaligned LW at 0x101.
        set_ex(32'h0, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1, M_XRD, MT_W, WB_MEM);
        dmem_req_ready = 1'b1;
        tick();
        set_bubble();
        #1;
        chk1("lw_mis_req", dmem_req_valid, 1'b0);
        chk1("lw_mis_flag", mem_misaligned, 1'b1);
        chk1("lw_mis_stall", mem_stall, 1'b0);
        chk1("lw_mis_bypass_wen", mem_rf_wen, 1'b0);
        tick();
        chk1("lw_mis_flag_clear", mem_misaligned, 1'b0);
        chk1("lw_mis_wb_rf_wen", wb_rf_wen, 1'b0);

        // ADD to x5 followed by JAL at 0x200.
        set_ex(32'h1F0, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 2'd0, 3'd0, WB_ALU);
        tick();
        set_ex(32'h200, 32'hABCD, 32'h0, 5'd1, 1'b1, 1'b0, 2'd0, 3'd0, WB_PC4);
        #1;
        check("add_bypass_data", mem_wb_data, 32'h1234);
        check("add_bypass_addr", 32'(mem_wb_addr), 32'd5);
        tick();
        set_bubble();
        #1;
        check("add_wb_data", wb_data, 32'h1234);
        check("add_wb_addr", 32'(wb_addr), 32'd5);
        chk1("add_wb_rf_wen", wb_rf_wen, 1'b1);
        check("jal_bypass_data", mem_wb_data, 32'h204);
        tick();
        check("jal_wb_data", wb_data, 32'h204);
        check("jal_wb_addr", 32'(wb_addr), 32'd1);
        chk1("jal_bypass_gone", mem_rf_wen, 1'b0);
        tick();
        chk1("jal_wb_clear", wb_rf_wen, 1'b0);

        // Reset while a load waits, then a late response.
        set_ex(32'h0, 32'h200, 32'h0, 5'd3, 1'b1, 1'b1, M_XRD, MT_W, WB_MEM);
        dmem_req_ready = 1'b1;
        tick();
        set_bubble();
        #1;
        chk1("rw_req_valid", dmem_req_valid, 1'b1);
        tick();
        chk1("rw_waiting", mem_stall, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("rw_req_valid_0", dmem_req_valid, 1'b0);
        chk1("rw_stall_0", mem_stall, 1'b0);
        chk1("rw_wb_rf_wen_0", wb_rf_wen, 1'b0);
        check("rw_wdata_0", dmem_req_wdata, 32'h0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1111_2222;
        #1;
        chk1("rw_late_resp_wen", mem_rf_wen, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        chk1("rw_late_resp_wb", wb_rf_wen, 1'b0);
        set_ex(32'h0, 32'h302, 32'h0, 5'd4, 1'b1, 1'b1, M_XRD, MT_HU, WB_MEM);
        tick();
        set_bubble();
        #1;
        check("rw_next_req_addr", dmem_req_addr, 32'h300);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFE_0001;
        #1;
        chk1("rw_next_stall", mem_stall, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        check("rw_next_wb_data", wb_data, 32'h0000_CAFE);
        chk1("rw_next_wb_rf_wen", wb_rf_wen, 1'b1);
        dmem_req_ready = 1'b0;
        tick();

        // Randomized stream with a responding memory and random backpressure.
        cyc = 0; issued = 0; resp_pend = 1'b0; resp_wait = 0; resp_addr = '0;
        cur = gen_instr();
        drive(cur);
        while (cyc < BUDGET && (issued < N_INSTR || wb_q.size() != 0 || req_q.size() != 0 || resp_pend)) begin
            dmem_req_ready = ($urandom_range(0, 2) != 0);
            if (resp_pend && resp_wait == 0) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = mem_word(resp_addr);
                resp_pend = 1'b0;
            end else begin
                if (resp_pend) resp_wait--;
                dmem_resp_valid = !resp_pend && !dmem_req_ready && ($urandom_range(0, 7) == 0);
                dmem_resp_rdata = $urandom;
            end
            #1;
            if (dmem_req_valid && dmem_req_ready) begin
                if (req_q.size() == 0) begin
                    chk1("rand_unexpected_req", 1'b1, 1'b0);
                end else begin
                    r = req_q.pop_front();
                    check("rand_req_addr", dmem_req_addr, r.addr);
                    chk1("rand_req_wen", dmem_req_wen, r.wen);
                    check("rand_req_be", 32'(dmem_req_be), 32'(r.be));
                    if (r.wen) check("rand_req_wdata", dmem_req_wdata, r.wdata);
                    else begin
                        resp_pend = 1'b1;
                        resp_wait = $urandom_range(0, 2);
                        resp_addr = r.addr;
                    end
                end
            end
            if (wb_rf_wen) begin
                if (wb_q.size() == 0) begin
                    chk1("rand_unexpected_wb", 1'b1, 1'b0);
                end else begin
                    w = wb_q.pop_front();
                    check("rand_wb_addr", 32'(wb_addr), 32'(w.addr));
                    check("rand_wb_data", wb_data, w.data);
                end
            end
            if (mem_misaligned) obs_mis++;
            if (!mem_stall) begin
                model_push(cur);
                if (issued < N_INSTR) begin
                    issued++;
                    cur = gen_instr();
                end else begin
                    cur = '0;
                end
            end
            tick();
            drive(cur);
            cyc++;
        end
        chk1("rand_within_budget", cyc < BUDGET, 1'b1);
        check("rand_req_q_empty", 32'(req_q.size()), 32'd0);
        check("rand_wb_q_empty", 32'(wb_q.size()), 32'd0);
        check("rand_misaligned_count", 32'(obs_mis), 32'(exp_mis));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
